// File: rtl/kwta_pkg.sv
// rtl/kwta_pkg.sv - shared types and sizing helpers for the k-winners-take-all column
package kwta_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      SAT    = 2'd2
   } state_e;

   // Width of a counter able to hold 0..k.
   function automatic int cnt_width(input int k);
      return (k < 1) ? 1 : $clog2(k + 1);
   endfunction

   function automatic int ptr_width(input int q);
      return (q > 1) ? $clog2(q) : 1;
   endfunction

endpackage

// File: rtl/kwta_select.sv
// rtl/kwta_select.sv - combinational pick of at most budget requests, scanning from ptr upward
module kwta_select
   import kwta_pkg::*;
#(
   parameter  int Q  = 10,
   parameter  int K  = 1,
   localparam int CW = cnt_width(K),
   localparam int PW = ptr_width(Q)
) (
   input  logic [Q-1:0]  req,
   input  logic [CW-1:0] budget,
   input  logic [PW-1:0] ptr,
   output logic [Q-1:0]  grant
);

   int taken;
   int idx;

   // Priority p maps to neuron (p + ptr) mod Q, so priority 0 is the neuron at ptr.
   always_comb begin
      grant = '0;
      taken = 0;
      idx   = 0;
      for (int p = 0; p < Q; p++) begin
         idx = (p + int'(ptr)) % Q;
         if (req[idx] && (taken < int'(budget))) begin
            grant[idx] = 1'b1;
            taken      = taken + 1;
         end
      end
   end

endmodule

// File: rtl/kwta.sv
// rtl/kwta.sv - k-winners-take-all lateral inhibition over temporally encoded spikes
// Optional rotating tie-break priority: define KWTA_ROUND_ROBIN_EN.
module kwta
   import kwta_pkg::*;
#(
   parameter  int Q  = 10,
   parameter  int K  = 1,
   localparam int CW = cnt_width(K),
   localparam int PW = ptr_width(Q)
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          grst,
   input  logic [Q-1:0]  ec_spikes,
   output logic [Q-1:0]  li_out,
   output logic [CW-1:0] win_cnt,
   output logic          sat
);

   if ((Q < 2) || (Q > 64)) begin : g_bad_q
      $error("kwta: Q must be within 2..64");
   end
   if ((K < 1) || (K > Q)) begin : g_bad_k
      $error("kwta: K must be within 1..Q");
   end

   logic [Q-1:0]  prev_q, prev_d;
   logic [Q-1:0]  mask_q, mask_d;
   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;

   logic [Q-1:0]  rise, req, grant;
   logic [CW-1:0] budget, grant_cnt;
   logic [PW-1:0] ptr;

`ifdef KWTA_ROUND_ROBIN_EN
   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (grst) begin
         ptr_d = (ptr_q == PW'(Q - 1)) ? '0 : ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   kwta_select #(.Q(Q), .K(K)) u_select (
      .req    (req),
      .budget (budget),
      .ptr    (ptr),
      .grant  (grant)
   );

   always_comb begin
      rise = ec_spikes & ~prev_q;
      // Existing winners re-pulsing pass through the mask and must not spend budget.
      req  = rise & ~mask_q;
      budget = ((state_q == SAT) || grst) ? '0 : CW'(K) - cnt_q;

      grant_cnt = '0;
      for (int i = 0; i < Q; i++) begin
         grant_cnt = grant_cnt + CW'(grant[i]);
      end

      prev_d  = ec_spikes;
      mask_d  = mask_q | grant;
      cnt_d   = cnt_q + grant_cnt;
      state_d = state_q;

      unique case (state_q)
         IDLE: begin
            if (cnt_d == CW'(K)) begin
               state_d = SAT;
            end else if (cnt_d != '0) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cnt_d == CW'(K)) begin
               state_d = SAT;
            end
         end
         SAT:     state_d = SAT;
         default: state_d = IDLE;
      endcase

      // A gamma restart forgets everything, including the previous input sample,
      // so a pulse still high afterwards is seen as a fresh onset.
      if (grst) begin
         prev_d  = '0;
         mask_d  = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end

      li_out = (grst || !rstb) ? '0 : (ec_spikes & (mask_q | grant));
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         prev_q  <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         state_q <= IDLE;
      end else begin
         prev_q  <= prev_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign win_cnt = cnt_q;
   assign sat     = (state_q == SAT);

endmodule

// File: tb/tb_kwta.sv
// tb/tb_kwta.sv - directed self-checking bench for kwta over four parameterisations
module tb_kwta;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic       rstb_a, grst_a, sat_a;
   logic [9:0] ec_a, li_a;
   logic [0:0] cnt_a;

   logic       rstb_b, grst_b, sat_b;
   logic [9:0] ec_b, li_b;
   logic [1:0] cnt_b;

   logic       rstb_c, grst_c, sat_c;
   logic [9:0] ec_c, li_c;
   logic [1:0] cnt_c;

   logic       rstb_d, grst_d, sat_d;
   logic [3:0] ec_d, li_d;
   logic [0:0] cnt_d;

   kwta #(.Q(10), .K(1)) dut_a (.clk(clk), .rstb(rstb_a), .grst(grst_a), .ec_spikes(ec_a),
                                .li_out(li_a), .win_cnt(cnt_a), .sat(sat_a));
   kwta #(.Q(10), .K(2)) dut_b (.clk(clk), .rstb(rstb_b), .grst(grst_b), .ec_spikes(ec_b),
                                .li_out(li_b), .win_cnt(cnt_b), .sat(sat_b));
   kwta #(.Q(10), .K(3)) dut_c (.clk(clk), .rstb(rstb_c), .grst(grst_c), .ec_spikes(ec_c),
                                .li_out(li_c), .win_cnt(cnt_c), .sat(sat_c));
   kwta #(.Q(4),  .K(1)) dut_d (.clk(clk), .rstb(rstb_d), .grst(grst_d), .ec_spikes(ec_d),
                                .li_out(li_d), .win_cnt(cnt_d), .sat(sat_d));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [9:0] e_li;
      logic [3:0] e_d;
      int         e_cnt;

      rstb_a = 1'b0; grst_a = 1'b0; ec_a = '0;
      rstb_b = 1'b0; grst_b = 1'b0; ec_b = '0;
      rstb_c = 1'b0; grst_c = 1'b0; ec_c = '0;
      rstb_d = 1'b0; grst_d = 1'b0; ec_d = '0;

      // Reset state, with an input high to show li_out is held low during reset.
      repeat (2) @(negedge clk);
      ec_a = 10'h001;
      #1;
      chk("rst_li_a", li_a, 0);
      @(negedge clk);
      #1;
      chk("rst_li_a2", li_a, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_sat_a", sat_a, 0);
      chk("rst_cnt_b", cnt_b, 0);
      chk("rst_sat_c", sat_c, 0);
      chk("rst_cnt_d", cnt_d, 0);
      @(negedge clk);
      rstb_a = 1'b1; rstb_b = 1'b1; rstb_c = 1'b1; rstb_d = 1'b1;
      ec_a = '0;

      // K=1: neuron 3 wins at t2, neuron 7 at t5 is inhibited, neuron 3 re-onsets at t10.
      for (int t = 0; t < 13; t++) begin
         @(negedge clk);
         ec_a = '0;
         if ((t >= 2 && t <= 5) || (t >= 10 && t <= 11)) ec_a[3] = 1'b1;
         if (t >= 5 && t <= 8) ec_a[7] = 1'b1;
         #1;
         e_li = ((t >= 2 && t <= 5) || (t >= 10 && t <= 11)) ? 10'h008 : 10'h000;
         chk($sformatf("a_li_t%0d", t), li_a, e_li);
         chk($sformatf("a_cnt_t%0d", t), cnt_a, (t >= 3) ? 1 : 0);
         chk($sformatf("a_sat_t%0d", t), sat_a, (t >= 3) ? 1 : 0);
      end

      // K=2: neurons 1,4,8 onset together; then a mid-gamma restart admits neuron 9.
      for (int t = 0; t < 7; t++) begin
         @(negedge clk);
         grst_b = (t == 3);
         ec_b   = (t < 3) ? 10'h112 : (t < 6) ? 10'h200 : 10'h000;
         #1;
         e_li  = (t < 3) ? 10'h012 : (t == 3 || t == 6) ? 10'h000 : 10'h200;
         e_cnt = (t == 0) ? 0 : (t <= 3) ? 2 : (t == 4) ? 0 : 1;
         chk($sformatf("b_li_t%0d", t), li_b, e_li);
         chk($sformatf("b_cnt_t%0d", t), cnt_b, e_cnt);
         chk($sformatf("b_sat_t%0d", t), sat_b, (e_cnt == 2) ? 1 : 0);
      end
      grst_b = 1'b0;

      // K=3: neuron 6 at t1, neurons 2 and 5 at t4, neuron 0 at t6 arrives after saturation.
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         ec_c = '0;
         if (t >= 1) ec_c[6] = 1'b1;
         if (t >= 4) begin ec_c[2] = 1'b1; ec_c[5] = 1'b1; end
         if (t >= 6) ec_c[0] = 1'b1;
         #1;
         e_li  = (t >= 4) ? 10'h064 : (t >= 1) ? 10'h040 : 10'h000;
         e_cnt = (t < 2) ? 0 : (t < 5) ? 1 : 3;
         chk($sformatf("c_li_t%0d", t), li_c, e_li);
         chk($sformatf("c_cnt_t%0d", t), cnt_c, e_cnt);
         chk($sformatf("c_sat_t%0d", t), sat_c, (t >= 5) ? 1 : 0);
      end

      // Reset pulse in the middle of an accepted output pulse.
      @(negedge clk);
      grst_c = 1'b1; ec_c = '0;
      #1;
      chk("c_grst_li", li_c, 0);
      for (int u = 0; u < 6; u++) begin
         @(negedge clk);
         grst_c = 1'b0;
         rstb_c = (u != 2);
         ec_c   = (u < 5) ? 10'h008 : 10'h000;
         #1;
         e_li  = (u == 2 || u == 5) ? 10'h000 : 10'h008;
         e_cnt = (u == 0 || u == 3) ? 0 : 1;
         chk($sformatf("r_li_u%0d", u), li_c, e_li);
         chk($sformatf("r_cnt_u%0d", u), cnt_c, e_cnt);
      end

      // Q=4, K=1: all four neurons tie in four consecutive gamma cycles.
      for (int g = 0; g < 4; g++) begin
`ifdef KWTA_ROUND_ROBIN_EN
         e_d = 4'b0001 << g;
`else
         e_d = 4'b0001;
`endif
         if (g > 0) begin
            @(negedge clk);
            grst_d = 1'b1; ec_d = 4'hf;
            #1;
            chk($sformatf("d_grst_li_g%0d", g), li_d, 0);
         end
         @(negedge clk);
         grst_d = 1'b0; ec_d = 4'hf;
         #1;
         chk($sformatf("d_li0_g%0d", g), li_d, e_d);
         chk($sformatf("d_cnt0_g%0d", g), cnt_d, 0);
         @(negedge clk);
         #1;
         chk($sformatf("d_li1_g%0d", g), li_d, e_d);
         chk($sformatf("d_sat_g%0d", g), sat_d, 1);
         @(negedge clk);
         ec_d = 4'h0;
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
